// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole bus cycle,
// with a watchdog that ends a stalled strobe with an error to the owner.
module wb_arbiter_2m #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,

    input  logic [aw-1:0] m0_adr_i,
    input  logic [dw-1:0] m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    input  logic          m0_we_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    output logic [dw-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic          m0_rty_o,

    input  logic [aw-1:0] m1_adr_i,
    input  logic [dw-1:0] m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    input  logic          m1_we_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    output logic [dw-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          m1_rty_o,

    output logic [aw-1:0] s_adr_o,
    output logic [dw-1:0] s_dat_o,
    output logic [3:0]    s_sel_o,
    output logic          s_we_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    input  logic [dw-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    input  logic          s_rty_i,

    output logic [1:0]    gnt_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    logic          last;
    logic [CW-1:0] wd_cnt;
    logic          wd_err;

    logic own0;
    logic own1;
    logic strobed;
    logic terminated;
    logic owner_drop;

    assign own0       = (state == OWN0);
    assign own1       = (state == OWN1);
    assign strobed    = s_cyc_o & s_stb_o;
    assign terminated = s_ack_i | s_err_i | s_rty_i;
    assign owner_drop = (own0 & ~m0_cyc_i) | (own1 & ~m1_cyc_i);

    // Every release passes through IDLE, so a tie is always settled by 'last'.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i)
                        state <= last ? OWN0 : OWN1;
                    else if (m0_cyc_i)
                        state <= OWN0;
                    else if (m1_cyc_i)
                        state <= OWN1;
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        state <= IDLE;
                        last  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        state <= IDLE;
                        last  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else if (!strobed || terminated || owner_drop) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else if (wd_cnt == WD_LAST) begin
            wd_cnt <= '0;
            wd_err <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
            wd_err <= 1'b0;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        case (state)
            OWN0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_cti_o = m0_cti_i;
                s_bte_o = m0_bte_i;
            end
            OWN1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_cti_o = m1_cti_i;
                s_bte_o = m1_bte_i;
            end
            default: ;
        endcase
    end

    // Terminations are combinational; an slave err and watchdog err merge into one pulse.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = own0 & s_ack_i;
    assign m1_ack_o = own1 & s_ack_i;
    assign m0_rty_o = own0 & s_rty_i;
    assign m1_rty_o = own1 & s_rty_i;
    assign m0_err_o = own0 & (s_err_i | wd_err);
    assign m1_err_o = own1 & (s_err_i | wd_err);
    assign gnt_o    = {own1, own0};

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios plus a randomized
// run compared against a transaction-level round-robin ownership model.
module tb_wb_arbiter_2m;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;

    logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0;
    logic [3:0]  m0_sel = '0, m1_sel = '0;
    logic        m0_we = 1'b0, m0_cyc = 1'b0, m0_stb = 1'b0;
    logic        m1_we = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
    logic [2:0]  m0_cti = '0, m1_cti = '0;
    logic [1:0]  m0_bte = '0, m1_bte = '0;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic        s_ack_i = 1'b0;
    logic        s_err_i = 1'b0;
    logic        s_rty_i = 1'b0;
    logic [1:0]  gnt_o;

    logic        slave_stall = 1'b0;
    logic [31:0] slave_mem [4];

    int checks = 0;
    int passes = 0;

    always #5 wb_clk = ~wb_clk;

    wb_arbiter_2m #(.dw(32), .aw(32), .TIMEOUT(16)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    // Four-register slave with a registered single-cycle ack; 'slave_stall' silences it.
    initial for (int i = 0; i < 4; i++) slave_mem[i] = '0;
    assign s_dat_i = slave_mem[s_adr_o[3:2]];
    always @(posedge wb_clk) begin
        if (s_cyc_o && s_stb_o && !s_ack_i && !slave_stall) begin
            s_ack_i <= 1'b1;
            if (s_we_o)
                for (int b = 0; b < 4; b++)
                    if (s_sel_o[b]) slave_mem[s_adr_o[3:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
        end else begin
            s_ack_i <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL tb_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic clear_masters();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat = '0;
        m0_sel = '0; m0_cti = '0; m0_bte = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat = '0;
        m1_sel = '0; m1_cti = '0; m1_bte = '0;
    endtask

    task automatic do_reset();
        wb_rst_n = 1'b0;
        clear_masters();
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
        slave_stall = 1'b0;
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        wb_rst_n = 1'b0;
        clear_masters();
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk);
        checks++;
        if (gnt_o !== 2'b00) $display("[TB] FAIL reset_gnt: got %b expected 00", gnt_o);
        else passes++;
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000)
            $display("[TB] FAIL reset_slave_req: got %b expected 000", {s_cyc_o, s_stb_o, s_we_o});
        else passes++;
        checks++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000)
            $display("[TB] FAIL reset_terms: got %b expected 0000",
                     {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        else passes++;
        wb_rst_n = 1'b1;
    endtask

    task automatic m0_access(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                             output logic [31:0] rdata, output int lat,
                             output logic [1:0] gnt_first, output logic we_first);
        @(posedge wb_clk);
        #1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = adr; m0_dat = dat; m0_we = we; m0_sel = 4'hF;
        lat = 0; rdata = '0; gnt_first = '0; we_first = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
            if (i == 1) begin
                gnt_first = gnt_o;
                we_first  = s_we_o;
            end
            if (m0_ack_o) begin
                lat   = i;
                rdata = m0_dat_o;
                break;
            end
        end
        @(posedge wb_clk);
        #1;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] rd;
        int          lat;
        logic [1:0]  g;
        logic        w;
        m0_access(32'h0, 32'hDEADBEEF, 1'b1, rd, lat, g, w);
        checks++;
        if (g !== 2'b01) $display("[TB] FAIL write_gnt: got %b expected 01", g);
        else passes++;
        checks++;
        if (w !== 1'b1) $display("[TB] FAIL write_we: got %b expected 1", w);
        else passes++;
        checks++;
        if (lat != 2) $display("[TB] FAIL write_latency: got %0d expected 2", lat);
        else passes++;
        m0_access(32'h0, 32'h0, 1'b0, rd, lat, g, w);
        checks++;
        if (lat != 2) $display("[TB] FAIL read_latency: got %0d expected 2", lat);
        else passes++;
        checks++;
        if (rd !== 32'hDEADBEEF) $display("[TB] FAIL read_data: got %h expected deadbeef", rd);
        else passes++;
    endtask

    task automatic test_tie();
        do_reset();
        @(posedge wb_clk);
        #1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h4;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h8;
        @(posedge wb_clk);
        @(negedge wb_clk);
        checks++;
        if (gnt_o !== 2'b01) $display("[TB] FAIL tie_first: got %b expected 01", gnt_o);
        else passes++;
        repeat (2) @(posedge wb_clk);
        #1;
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(posedge wb_clk);
        @(negedge wb_clk);
        checks++;
        if (gnt_o !== 2'b00) $display("[TB] FAIL handover_idle: got %b expected 00", gnt_o);
        else passes++;
        @(posedge wb_clk);
        @(negedge wb_clk);
        checks++;
        if (gnt_o !== 2'b10) $display("[TB] FAIL handover_m1: got %b expected 10", gnt_o);
        else passes++;
        checks++;
        if (s_adr_o !== 32'h8) $display("[TB] FAIL handover_adr: got %h expected 00000008", s_adr_o);
        else passes++;
        #1;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        @(posedge wb_clk);
        #1;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        @(posedge wb_clk);
        @(negedge wb_clk);
        checks++;
        if (gnt_o !== 2'b01) $display("[TB] FAIL tie_alternate: got %b expected 01", gnt_o);
        else passes++;
        #1;
        clear_masters();
        repeat (2) @(posedge wb_clk);
    endtask

    task automatic test_hold();
        int acks = 0;
        int bad_gnt = 0;
        int bad_ack = 0;
        @(posedge wb_clk);
        #1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'hC;
        @(posedge wb_clk);
        #1;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h4;
        for (int i = 0; i < 30 && acks < 4; i++) begin
            @(negedge wb_clk);
            if (gnt_o !== 2'b01) bad_gnt++;
            if (m1_ack_o !== 1'b0) bad_ack++;
            if (m0_ack_o) acks++;
            @(posedge wb_clk);
        end
        checks++;
        if (acks != 4) $display("[TB] FAIL hold_acks: got %0d expected 4", acks);
        else passes++;
        checks++;
        if (bad_gnt != 0) $display("[TB] FAIL hold_gnt: got %0d bad cycles expected 0", bad_gnt);
        else passes++;
        checks++;
        if (bad_ack != 0) $display("[TB] FAIL hold_m1_ack: got %0d bad cycles expected 0", bad_ack);
        else passes++;
        #1;
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(posedge wb_clk);
        @(negedge wb_clk);
        checks++;
        if (gnt_o !== 2'b00) $display("[TB] FAIL hold_release_idle: got %b expected 00", gnt_o);
        else passes++;
        @(posedge wb_clk);
        @(negedge wb_clk);
        checks++;
        if (gnt_o !== 2'b10) $display("[TB] FAIL hold_release_m1: got %b expected 10", gnt_o);
        else passes++;
        #1;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        repeat (2) @(posedge wb_clk);
    endtask

    task automatic test_watchdog();
        int first_err = 0;
        int pulses = 0;
        int m1_errs = 0;
        slave_stall = 1'b1;
        @(posedge wb_clk);
        #1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h4;
        for (int i = 1; i <= 30; i++) begin
            @(posedge wb_clk);
            @(negedge wb_clk);
            if (m0_err_o) begin
                pulses++;
                if (first_err == 0) first_err = i;
            end
            if (m1_err_o) m1_errs++;
        end
        checks++;
        if (first_err != 17) $display("[TB] FAIL wd_timing: got cycle %0d expected 17", first_err);
        else passes++;
        checks++;
        if (pulses != 1) $display("[TB] FAIL wd_pulses: got %0d expected 1", pulses);
        else passes++;
        checks++;
        if (m1_errs != 0) $display("[TB] FAIL wd_m1_err: got %0d expected 0", m1_errs);
        else passes++;
        @(posedge wb_clk);
        #1;
        m0_cyc = 1'b0; m0_stb = 1'b0;
        slave_stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        int found = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge wb_clk);
            if (m1_ack_o) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found != 1) $display("[TB] FAIL rst_mid_setup: got ack %0d expected 1", found);
        else passes++;
        checks++;
        if (gnt_o !== 2'b10) $display("[TB] FAIL rst_mid_owner: got %b expected 10", gnt_o);
        else passes++;
        wb_rst_n = 1'b0;
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o} !== 2'b00)
            $display("[TB] FAIL rst_mid_slave: got %b expected 00", {s_cyc_o, s_stb_o});
        else passes++;
        checks++;
        if (gnt_o !== 2'b00) $display("[TB] FAIL rst_mid_gnt: got %b expected 00", gnt_o);
        else passes++;
        checks++;
        if ({m0_ack_o, m1_ack_o} !== 2'b00)
            $display("[TB] FAIL rst_mid_ack: got %b expected 00", {m0_ack_o, m1_ack_o});
        else passes++;
        clear_masters();
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(posedge wb_clk);
        #1;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        @(posedge wb_clk);
        @(negedge wb_clk);
        checks++;
        if (gnt_o !== 2'b01) $display("[TB] FAIL rst_mid_tie: got %b expected 01", gnt_o);
        else passes++;
        clear_masters();
    endtask

    task automatic rand_master(input logic cur_cyc, output logic cyc, output logic stb,
                               output logic [31:0] adr, output logic [31:0] dat,
                               output logic [3:0] sel, output logic we,
                               output logic [2:0] cti, output logic [1:0] bte);
        if (!cur_cyc) cyc = ($urandom_range(0, 3) == 0);
        else          cyc = ($urandom_range(0, 5) != 0);
        stb = cyc & ($urandom_range(0, 1) == 1);
        adr = $urandom;
        dat = $urandom;
        sel = 4'($urandom);
        we  = 1'($urandom);
        cti = 3'($urandom);
        bte = 2'($urandom);
    endtask

    // Reference: owner is -1 when idle; ties go to the master that did not own last.
    task automatic test_random();
        int          owner = -1;
        int          last_owner = 1;
        int          errors = 0;
        logic [1:0]  exp_gnt;
        logic        exp_cyc;
        logic [31:0] exp_adr;
        do_reset();
        for (int cyc_n = 0; cyc_n < 600; cyc_n++) begin
            @(posedge wb_clk);
            if (owner == 0 && !m0_cyc) begin
                last_owner = 0;
                owner = -1;
            end else if (owner == 1 && !m1_cyc) begin
                last_owner = 1;
                owner = -1;
            end else if (owner == -1) begin
                if (m0_cyc && m1_cyc) owner = 1 - last_owner;
                else if (m0_cyc)      owner = 0;
                else if (m1_cyc)      owner = 1;
            end
            #1;
            rand_master(m0_cyc, m0_cyc, m0_stb, m0_adr, m0_dat, m0_sel, m0_we, m0_cti, m0_bte);
            rand_master(m1_cyc, m1_cyc, m1_stb, m1_adr, m1_dat, m1_sel, m1_we, m1_cti, m1_bte);
            s_err_i = ($urandom_range(0, 15) == 0);
            s_rty_i = ($urandom_range(0, 15) == 0);
            @(negedge wb_clk);
            exp_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            exp_cyc = (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0;
            exp_adr = (owner == 0) ? m0_adr : (owner == 1) ? m1_adr : 32'h0;
            checks++;
            if (gnt_o !== exp_gnt) begin
                $display("[TB] FAIL rand_gnt cycle %0d: got %b expected %b", cyc_n, gnt_o, exp_gnt);
                errors++;
            end else passes++;
            checks++;
            if ({s_cyc_o, s_adr_o} !== {exp_cyc, exp_adr}) begin
                $display("[TB] FAIL rand_mux cycle %0d: got %b/%h expected %b/%h",
                         cyc_n, s_cyc_o, s_adr_o, exp_cyc, exp_adr);
                errors++;
            end else passes++;
            checks++;
            if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_rty_o, m1_rty_o} !==
                {(owner == 0) & s_ack_i, (owner == 1) & s_ack_i,
                 (owner == 0) & s_err_i, (owner == 1) & s_err_i,
                 (owner == 0) & s_rty_i, (owner == 1) & s_rty_i}) begin
                $display("[TB] FAIL rand_terms cycle %0d: got %b expected owner %0d ack %b err %b rty %b",
                         cyc_n, {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_rty_o, m1_rty_o},
                         owner, s_ack_i, s_err_i, s_rty_i);
                errors++;
            end else passes++;
            if (errors > 20) break;
        end
        #1;
        clear_masters();
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_hold();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone arbiter that lets two requesters share one Wishbone slave port, such as the 4-register test slave or a DSP configuration slave. Arbitration is round-robin, and a grant is held for a master's whole bus cycle, so bursts and read-modify-write sequences are never split. A watchdog ends a stalled access with an error to the owning master. The block sits between the masters and the slave on the `wb_clk` domain.

## Interface
Parameters:
- `dw`, 32, data width
- `aw`, 32, address width
- `TIMEOUT`, 16, cycles a strobed access may wait for ack/err/rty before the arbiter returns err; minimum 2

Ports:
- `wb_clk`  in  1  clock; all logic on rising edge
- `wb_rst_n`  in  1  reset, asynchronous assert, active-low
- `m0_adr_i`, `m1_adr_i`  in  aw  master address
- `m0_dat_i`, `m1_dat_i`  in  dw  master write data
- `m0_sel_i`, `m1_sel_i`  in  4  byte selects
- `m0_we_i`, `m1_we_i`  in  1  write enable
- `m0_cyc_i`, `m1_cyc_i`  in  1  cycle valid; acts as the bus request
- `m0_stb_i`, `m1_stb_i`  in  1  strobe
- `m0_cti_i`, `m1_cti_i`  in  3  cycle type
- `m0_bte_i`, `m1_bte_i`  in  2  burst type
- `m0_dat_o`, `m1_dat_o`  out  dw  read data; both are `s_dat_i` passed straight through
- `m0_ack_o`, `m1_ack_o`, `m0_err_o`, `m1_err_o`, `m0_rty_o`, `m1_rty_o`  out  1  termination signals, gated to the current owner
- `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `s_cyc_o`, `s_stb_o`, `s_cti_o`, `s_bte_o`  out  (as above)  slave-side request, muxed from the owner
- `s_dat_i`, `s_ack_i`, `s_err_i`, `s_rty_i`  in  (as above)  slave-side response
- `gnt_o`  out  2  one-hot owner: `01` = m0, `10` = m1, `00` = idle

## Operation
- States: `IDLE`, `OWN0`, `OWN1`. State register plus a `last` bit (last owner); `last` resets to 1 so m0 wins the first tie.
- `IDLE`:
  - only `m0_cyc_i` set → `OWN0`
  - only `m1_cyc_i` set → `OWN1`
  - both set → owner is the master not equal to `last`
  - neither set → stay in `IDLE`
- `OWNx`:
  - stay while `mx_cyc_i` = 1
  - `mx_cyc_i` = 0 → `IDLE`, and `last` <= x
  - the other master's request is ignored until then
- Request mux (combinational from state):
  - `OWNx` → `s_*_o` = `mx_*_i`
  - `IDLE` → `s_cyc_o` = `s_stb_o` = `s_we_o` = 0, `s_sel_o` = 0, `s_adr_o`/`s_dat_o`/`s_cti_o`/`s_bte_o` = 0
- Response gating:
  - `mx_ack_o` = `OWNx` & `s_ack_i`, likewise for rty.
  - `mx_err_o` = `OWNx` & (`s_err_i` | `wd_err`).
  - The non-owner sees 0 on ack, err and rty.
- Watchdog:
  - Counter width is ceil(log2(`TIMEOUT`)).
  - Increments each cycle with `s_cyc_o` & `s_stb_o` & ~(`s_ack_i` | `s_err_i` | `s_rty_i`).
  - Clears on any termination, on `s_stb_o` = 0, and on leaving an `OWN` state.
  - At count `TIMEOUT`-1 with no termination, `wd_err` is registered high for exactly one cycle and the counter clears.
  - The slave still sees its strobe. A late slave ack is forwarded normally if the master keeps `stb` high.
- Simultaneous events:
  - Owner drops `cyc` while the other requests → one `IDLE` cycle, then grant to the other.
  - `s_err_i` coincident with `wd_err` → a single err pulse to the owner.
- Reset (async, any time, including mid-transfer):
  - state `IDLE`, `last` = 1, counter 0, `wd_err` 0
  - every output 0, `gnt_o` = `00`
  - an in-flight slave access is abandoned with no termination to the master

## Timing
- Master asserts `cyc`/`stb` at edge N while `IDLE` → `OWNx` and `gnt_o` at N+1, and `s_cyc_o`/`s_stb_o` visible in cycle N+1.
  - A registered-ack slave acks in cycle N+2, so single-access latency is 2 cycles from request.
- Handover: owner drops `cyc` at edge K → `IDLE` in cycle K+1 → other master owned from K+2. Exactly one dead cycle between owners.
- Back-to-back cycles by the same master with no competitor still pass through one `IDLE` cycle.
- Ack, err and rty are combinational from `s_*_i` and state, with zero added latency; `wd_err` is registered.
- Watchdog: stalled strobe from cycle S → `mx_err_o` high in cycle S+`TIMEOUT`.

## Test plan
- Reset then m0 writes 0xDEADBEEF to addr 0x0 with sel=0xF → `gnt_o`=`01` one cycle after request, `s_we_o`=1, `m0_ack_o` after 2 cycles; m0 reads addr 0x0 and gets 0xDEADBEEF.
- m0 and m1 request in the same cycle after reset → m0 granted first. After m0 drops `cyc`: 1 `IDLE` cycle, then `gnt_o`=`10`. Repeat the tie → m0 granted (alternation).
- m0 holds `cyc` across 4 strobed accesses while m1 requests continuously → `gnt_o` stays `01` throughout; `m1_ack_o` stays 0 until m0 releases.
- Slave never acks, `TIMEOUT`=16 → `m0_err_o` pulses once, exactly 16 cycles after strobe start; `m1_err_o` stays 0.
- Assert `wb_rst_n`=0 mid-access while `OWN1` → `s_cyc_o`, `gnt_o` and all acks 0 immediately without a clock edge; after release, m0 wins the first tie.
